lsu_st_gen: RTL



---
 rtl/lsu_st_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_st_gen.sv
// Store-request generator: one AW request per command, ORAM-fed W beats with WLAST framing, B-response collection.
// Latency: AWVALID the cycle after command accept; first WVALID 3 cycles after AW handshake; then 1 beat/cycle.
// Backpressure: WREADY low freezes the beat and throttles ORAM reads so the 2-entry prefetch FIFO never overflows.
module lsu_st_gen #(
    parameter int ORAM_AW = 12,
    parameter int DATA_W  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_vld_i,
    output logic                  cmd_rdy_o,
    input  logic [9:0]            cmd_awaddr_i,
    input  logic [7:0]            cmd_awlen_i,
    input  logic [2:0]            cmd_awstr_i,
    input  logic [3:0]            cmd_awnum_i,
    input  logic [ORAM_AW-1:0]    cmd_oram_addr_i,
    output logic                  oram_rd_en_o,
    output logic [ORAM_AW-1:0]    oram_rd_addr_o,
    input  logic [DATA_W-1:0]     oram_rd_data_i,
    output logic [7:0]            lsu_axi_awid_o,
    output logic [9:0]            lsu_axi_awaddr_o,
    output logic [7:0]            lsu_axi_awlen_o,
    output logic [2:0]            lsu_axi_awsize_o,
    output logic [1:0]            lsu_axi_awburst_o,
    output logic [2:0]            lsu_axi_awstr_o,
    output logic [3:0]            lsu_axi_awnum_o,
    output logic [ORAM_AW-1:0]    lsu_axi_oram_addr_o,
    output logic                  lsu_axi_awvld_o,
    input  logic                  axi_lsu_awrdy_i,
    output logic [DATA_W-1:0]     lsu_axi_wdata_o,
    output logic [DATA_W/8-1:0]   lsu_axi_wstrb_o,
    output logic                  lsu_axi_wlast_o,
    output logic                  lsu_axi_wvld_o,
    input  logic                  axi_lsu_wrdy_i,
    input  logic                  axi_lsu_bvld_i,
    output logic                  lsu_axi_brdy_o,
    input  logic [1:0]            axi_lsu_bresp_i,
    output logic                  st_busy_o,
    output logic                  st_done_o,
    output logic                  st_err_o
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_DATA, S_WAIT_B, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [9:0]          awaddr_q;
    logic [7:0]          awlen_q;
    logic [2:0]          awstr_q;
    logic [3:0]          awnum_q;
    logic [ORAM_AW-1:0]  oram_base_q;
    logic [ORAM_AW-1:0]  rd_addr_q;
    logic [12:0]         rd_cnt_q;
    logic [12:0]         beat_cnt_q;
    logic [7:0]          burst_cnt_q;
    logic [4:0]          resp_cnt_q;
    logic                err_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic                wr_ptr_q, rd_ptr_q;
    logic [1:0]          fifo_cnt_q;

    logic [12:0]         total_beats;
    logic [1:0]          pending;
    logic                cmd_fire, aw_fire, w_fire, b_fire;
    logic                rd_en, wvld, last_beat, resp_all;

    // Product of burst count and burst length never exceeds 4096, so 13 bits suffice.
    assign total_beats = ({9'd0, awnum_q} + 13'd1) * ({5'd0, awlen_q} + 13'd1);

    assign cmd_fire  = cmd_rdy_o & cmd_vld_i;
    assign aw_fire   = lsu_axi_awvld_o & axi_lsu_awrdy_i;
    assign w_fire    = wvld & axi_lsu_wrdy_i;
    assign b_fire    = lsu_axi_brdy_o & axi_lsu_bvld_i;
    assign last_beat = (beat_cnt_q == total_beats - 13'd1);
    assign resp_all  = ((resp_cnt_q + {4'd0, b_fire}) == ({1'b0, awnum_q} + 5'd1));

    // Slots committed after this cycle's pop; counting the pop lets a full FIFO refill while draining at 1 beat/cycle.
    assign pending = fifo_cnt_q - {1'b0, w_fire} + {1'b0, inflight_q};

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_vld_i)            state_d = S_AW;
            S_AW:     if (axi_lsu_awrdy_i)      state_d = S_DATA;
            S_DATA:   if (w_fire && last_beat)  state_d = S_WAIT_B;
            S_WAIT_B: if (resp_all)             state_d = S_DONE;
            S_DONE:                             state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs and handshakes.
    always_comb begin
        cmd_rdy_o         = (state_q == S_IDLE);
        lsu_axi_awvld_o   = (state_q == S_AW);
        lsu_axi_brdy_o    = (state_q == S_AW) || (state_q == S_DATA) || (state_q == S_WAIT_B);
        st_busy_o         = (state_q != S_IDLE);
        st_done_o         = (state_q == S_DONE);
        wvld              = (state_q == S_DATA) && (fifo_cnt_q != 2'd0);
        rd_en             = (state_q == S_DATA) && (pending < 2'd2) && (rd_cnt_q < total_beats);
        lsu_axi_awsize_o  = lsu_axi_awvld_o ? 3'b011 : 3'b000;
        lsu_axi_awburst_o = lsu_axi_awvld_o ? 2'b01  : 2'b00;
    end

    assign lsu_axi_awid_o      = 8'd0;
    assign lsu_axi_awaddr_o    = awaddr_q;
    assign lsu_axi_awlen_o     = awlen_q;
    assign lsu_axi_awstr_o     = awstr_q;
    assign lsu_axi_awnum_o     = awnum_q;
    assign lsu_axi_oram_addr_o = oram_base_q;
    assign oram_rd_en_o        = rd_en;
    assign oram_rd_addr_o      = rd_addr_q;
    assign lsu_axi_wvld_o      = wvld;
    assign lsu_axi_wdata_o     = wvld ? fifo_q[rd_ptr_q] : '0;
    assign lsu_axi_wstrb_o     = wvld ? '1 : '0;
    assign lsu_axi_wlast_o     = wvld && (burst_cnt_q == awlen_q);
    assign st_err_o            = err_q;

    // Command latch, read issue, prefetch FIFO, beat/burst/response counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awstr_q     <= '0;
            awnum_q     <= '0;
            oram_base_q <= '0;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
        end else if (cmd_fire) begin
            awaddr_q    <= cmd_awaddr_i;
            awlen_q     <= cmd_awlen_i;
            awstr_q     <= cmd_awstr_i;
            awnum_q     <= cmd_awnum_i;
            oram_base_q <= cmd_oram_addr_i;
            rd_addr_q   <= cmd_oram_addr_i;
            rd_cnt_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            resp_cnt_q  <= '0;
            err_q       <= 1'b0;
            inflight_q  <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                rd_addr_q <= rd_addr_q + 1'b1;
                rd_cnt_q  <= rd_cnt_q + 13'd1;
            end
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= oram_rd_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_fire) begin
                rd_ptr_q    <= ~rd_ptr_q;
                beat_cnt_q  <= beat_cnt_q + 13'd1;
                burst_cnt_q <= lsu_axi_wlast_o ? 8'd0 : burst_cnt_q + 8'd1;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, w_fire};
            if (b_fire) begin
                resp_cnt_q <= resp_cnt_q + 5'd1;
                if (axi_lsu_bresp_i != 2'b00) err_q <= 1'b1;
            end
        end
    end

endmodule
